// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the IF/ID pipeline bundle used by the fetch stage.
package rv32_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] instr;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with next-PC selection (redirect > stall > increment).
// IF_MISALIGN_TRAP_EN: misaligned redirect targets freeze the PC and raise a sticky flag.
module if_pc_reg
   import rv32_pkg::*;
#(
   parameter int unsigned WIDTH = XLEN,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   output logic [WIDTH-1:0] pc,
   output logic             misalign
);

   logic [WIDTH-1:0] pc_q, pc_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

`ifdef IF_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;
   logic target_bad;

   assign target_bad = redirect_target[1:0] != 2'b00;

   always_comb begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
      // Once trapped, the PC is frozen until reset regardless of redirects.
      if (misalign_q) begin
         pc_d = pc_q;
      end else if (redirect_valid) begin
         if (target_bad) begin
            misalign_d = 1'b1;
         end else begin
            pc_d = redirect_target;
         end
      end else if (!stall) begin
         pc_d = pc_q + WIDTH'(4);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign misalign = misalign_q;
`else
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         // Low two bits are dropped so the PC can never become misaligned.
         pc_d = redirect_target & ~WIDTH'(3);
      end else if (!stall) begin
         pc_d = pc_q + WIDTH'(4);
      end
   end

   assign misalign = 1'b0;
`endif

   assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// RV32I fetch stage: PC register plus the IF/ID pipeline register feeding decode.
// Optional IF_MISALIGN_TRAP_EN enables the sticky misaligned-redirect trap.
module instruction_fetch_stage
   import rv32_pkg::*;
#(
   parameter int unsigned WIDTH = XLEN,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic [WIDTH-1:0] Instruction,
   output logic [WIDTH-1:0] Read_address,
   output logic [WIDTH-1:0] if_id_pc,
   output logic [WIDTH-1:0] if_id_pc_plus4,
   output logic [WIDTH-1:0] if_id_instr,
   output logic             if_id_valid,
   output logic             fetch_misalign
);

   logic [WIDTH-1:0] pc;
   logic             bubble;
   if_id_t           if_id_q, if_id_d;

   if_pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .pc              (pc),
      .misalign        (fetch_misalign)
   );

   // A trapped fetch keeps feeding bubbles so decode never sees stale work.
   assign bubble = flush | redirect_valid | fetch_misalign;

   always_comb begin
      if_id_d = if_id_q;
      if (bubble) begin
         if_id_d.pc       = pc;
         if_id_d.pc_plus4 = pc + WIDTH'(4);
         if_id_d.instr    = NOP_INSTR;
         if_id_d.valid    = 1'b0;
      end else if (!stall) begin
         if_id_d.pc       = pc;
         if_id_d.pc_plus4 = pc + WIDTH'(4);
         if_id_d.instr    = Instruction;
         if_id_d.valid    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_id_q.pc       <= '0;
         if_id_q.pc_plus4 <= '0;
         if_id_q.instr    <= NOP_INSTR;
         if_id_q.valid    <= 1'b0;
      end else begin
         if_id_q <= if_id_d;
      end
   end

   assign Read_address   = pc;
   assign if_id_pc       = if_id_q.pc;
   assign if_id_pc_plus4 = if_id_q.pc_plus4;
   assign if_id_instr    = if_id_q.instr;
   assign if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized traffic against a model.
module tb_instruction_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, redirect_valid;
   logic [31:0] redirect_target, Instruction, Read_address;
   logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
   logic        if_id_valid, fetch_misalign;

   logic [31:0] imem [64];

   int passed = 0;
   int total  = 0;

   // Model state
   logic [31:0] m_pc, m_ipc, m_ip4, m_instr;
   logic        m_valid, m_mis;

   instruction_fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .Instruction     (Instruction),
      .Read_address    (Read_address),
      .if_id_pc        (if_id_pc),
      .if_id_pc_plus4  (if_id_pc_plus4),
      .if_id_instr     (if_id_instr),
      .if_id_valid     (if_id_valid),
      .fetch_misalign  (fetch_misalign)
   );

   always #5 clk = ~clk;

   assign Instruction = (Read_address < 32'h100) ? imem[Read_address[7:2]] : 32'h0;

   wire [129:0] obs = {Read_address, if_id_pc, if_id_pc_plus4, if_id_instr,
                       if_id_valid, fetch_misalign};

   function automatic logic [129:0] exp_vec();
      return {m_pc, m_ipc, m_ip4, m_instr, m_valid, m_mis};
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'h100) return imem[a[7:2]];
      return 32'h0;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0; m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0;
   endtask

   // One clock edge of the fetch stage, straight from the behavioural rules.
   task automatic model_edge(input logic st, input logic fl, input logic rv,
                             input logic [31:0] tgt);
      logic [31:0] cur_pc;
      logic        bad, bub;
      cur_pc = m_pc;
`ifdef IF_MISALIGN_TRAP_EN
      bad = rv && (tgt % 4 != 0);
`else
      bad = 1'b0;
`endif
      bub = fl || rv || m_mis;
      if (m_mis || bad) m_pc = cur_pc;
      else if (rv) m_pc = tgt - (tgt % 4);
      else if (!st) m_pc = cur_pc + 4;
      if (bub) begin
         m_ipc = cur_pc; m_ip4 = cur_pc + 4; m_instr = NOP; m_valid = 1'b0;
      end else if (!st) begin
         m_ipc = cur_pc; m_ip4 = cur_pc + 4; m_instr = mem_word(cur_pc); m_valid = 1'b1;
      end
      if (bad) m_mis = 1'b1;
   endtask

   // Called at a negedge: drive inputs, take one edge, land on the next negedge.
   task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] tgt);
      stall = st; flush = fl; redirect_valid = rv; redirect_target = tgt;
      @(posedge clk);
      model_edge(st, fl, rv, tgt);
      @(negedge clk);
      stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      total++;
      if (obs !== exp_vec()) $display("FAIL reset_state got=%h want=%h", obs, exp_vec());
      else passed++;
      total++;
      if (if_id_instr !== 32'h0000_0013) $display("FAIL reset_nop got=%h want=00000013", if_id_instr);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_free_run();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (Read_address !== 32'(i * 4))
            $display("FAIL free_run_addr%0d got=%h want=%h", i, Read_address, 32'(i * 4));
         else passed++;
         step(1'b0, 1'b0, 1'b0, 32'h0);
         total++;
         if (obs !== exp_vec()) $display("FAIL free_run%0d got=%h want=%h", i, obs, exp_vec());
         else passed++;
      end
   endtask

   task automatic test_stall();
      do_reset();
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         total++;
         if (Read_address !== 32'h8 || if_id_instr !== 32'h00C0_0193 || obs !== exp_vec())
            $display("FAIL stall_hold%0d got=%h want=%h", i, obs, exp_vec());
         else passed++;
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      total++;
      if (Read_address !== 32'hC || if_id_instr !== 32'hFF71_8393 || obs !== exp_vec())
         $display("FAIL stall_release got=%h want=%h", obs, exp_vec());
      else passed++;
   endtask

   task automatic test_redirect();
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
      total++;
      if (Read_address !== 32'h18) $display("FAIL redirect_pre got=%h want=00000018", Read_address);
      else passed++;
      step(1'b0, 1'b0, 1'b1, 32'h48);
      total++;
      if (Read_address !== 32'h48 || if_id_instr !== NOP || if_id_valid !== 1'b0 ||
          obs !== exp_vec())
         $display("FAIL redirect_bubble got=%h want=%h", obs, exp_vec());
      else passed++;
      step(1'b0, 1'b0, 1'b0, 32'h0);
      total++;
      if (if_id_instr !== 32'h0091_0133 || if_id_pc !== 32'h48 || obs !== exp_vec())
         $display("FAIL redirect_target_fetch got=%h want=%h", obs, exp_vec());
      else passed++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h10);
      total++;
      if (Read_address !== 32'h10 || if_id_valid !== 1'b0 || obs !== exp_vec())
         $display("FAIL redirect_stall got=%h want=%h", obs, exp_vec());
      else passed++;
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      total++;
      if (Read_address !== 32'h14 || if_id_valid !== 1'b0 || obs !== exp_vec())
         $display("FAIL flush_stall got=%h want=%h", obs, exp_vec());
      else passed++;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
      total++;
      if (Read_address !== 32'h2C) $display("FAIL async_pre got=%h want=0000002c", Read_address);
      else passed++;
      #2 rst = 1'b0;
      model_reset();
      #1;
      total++;
      if (Read_address !== 32'h0 || if_id_valid !== 1'b0 || obs !== exp_vec())
         $display("FAIL async_reset got=%h want=%h", obs, exp_vec());
      else passed++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_misalign();
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h22);
`ifdef IF_MISALIGN_TRAP_EN
      total++;
      if (Read_address !== 32'hC || fetch_misalign !== 1'b1 || obs !== exp_vec())
         $display("FAIL misalign_trap got=%h want=%h", obs, exp_vec());
      else passed++;
`else
      total++;
      if (Read_address !== 32'h20 || fetch_misalign !== 1'b0 || obs !== exp_vec())
         $display("FAIL misalign_force got=%h want=%h", obs, exp_vec());
      else passed++;
`endif
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0);
         total++;
         if (obs !== exp_vec()) $display("FAIL misalign_after%0d got=%h want=%h", i, obs, exp_vec());
         else passed++;
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      total++;
      if (Read_address !== 32'h0 || if_id_pc_plus4 !== 32'h0 || if_id_instr !== 32'h0 ||
          if_id_valid !== 1'b1 || obs !== exp_vec())
         $display("FAIL pc_wrap got=%h want=%h", obs, exp_vec());
      else passed++;
   endtask

   task automatic test_random();
      logic        st, fl, rv;
      logic [31:0] tgt;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 5) == 0);
         rv  = ($urandom_range(0, 7) == 0);
         tgt = 32'($urandom_range(0, 79) * 4);
         if ($urandom_range(0, 15) == 0) tgt = tgt + 32'($urandom_range(1, 3));
         step(st, fl, rv, tgt);
         total++;
         if (obs !== exp_vec()) $display("FAIL random%0d got=%h want=%h", i, obs, exp_vec());
         else passed++;
      end
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      for (int i = 0; i < 64; i++) imem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      imem[0]    = 32'h0050_0113;
      imem[1]    = 32'h00C0_0193;
      imem[2]    = 32'hFF71_8393;
      imem[5'h12] = 32'h0091_0133;
      model_reset();
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_simultaneous();
      test_async_reset();
      test_misalign();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
